mem_port_arbiter: RTL and testbench

- Shares the single external memory port (req / req_data / resp channels toward the external memory model) between two cache clients: client 0 = icache, client 1 = dcache.
- Arbitrates requests and locks the write-data channel to the granted client for a whole write.
- Routes responses back to the requester using the top bit of the memory tag.
- Sits in `riscv_top` between the cache subsystem and the top-level `mem_*` ports.

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-client arbiter for the shared external memory port (client 0 = icache, client 1 = dcache).
// Optional MEM_ARB_FIXED_PRIO_EN: on a tie client 1 always wins; otherwise round-robin.

module mem_arb_resp_lane #(
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128,
  parameter int CLIENT    = 0
) (
  input  logic                 mem_resp_valid,
  input  logic [TAG_BITS-1:0]  mem_resp_tag,
  input  logic [DATA_BITS-1:0] mem_resp_data,
  output logic                 resp_valid,
  output logic [TAG_BITS-2:0]  resp_tag,
  output logic [DATA_BITS-1:0] resp_data
);
  // Tag MSB carries the owning client; the rest is the client's own tag.
  assign resp_valid = mem_resp_valid && (mem_resp_tag[TAG_BITS-1] == 1'(CLIENT));
  assign resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign resp_data  = mem_resp_data;
endmodule

module mem_port_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5,
  parameter int WR_BEATS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req_valid,
  output logic                   c0_req_ready,
  input  logic                   c0_req_rw,
  input  logic [ADDR_BITS-1:0]   c0_req_addr,
  input  logic [TAG_BITS-2:0]    c0_req_tag,
  input  logic                   c0_req_data_valid,
  output logic                   c0_req_data_ready,
  input  logic [DATA_BITS-1:0]   c0_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
  output logic                   c0_resp_valid,
  output logic [TAG_BITS-2:0]    c0_resp_tag,
  output logic [DATA_BITS-1:0]   c0_resp_data,
  input  logic                   c1_req_valid,
  output logic                   c1_req_ready,
  input  logic                   c1_req_rw,
  input  logic [ADDR_BITS-1:0]   c1_req_addr,
  input  logic [TAG_BITS-2:0]    c1_req_tag,
  input  logic                   c1_req_data_valid,
  output logic                   c1_req_data_ready,
  input  logic [DATA_BITS-1:0]   c1_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
  output logic                   c1_resp_valid,
  output logic [TAG_BITS-2:0]    c1_resp_tag,
  output logic [DATA_BITS-1:0]   c1_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int NUM_CLIENTS = 2;
  localparam int MASK_BITS   = DATA_BITS/8;
  localparam int CNT_W       = $clog2(WR_BEATS) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic [NUM_CLIENTS-1:0]                 req_valid, req_rw, req_data_valid;
  logic [NUM_CLIENTS-1:0]                 req_ready, req_data_ready;
  logic [NUM_CLIENTS-1:0][ADDR_BITS-1:0]  req_addr;
  logic [NUM_CLIENTS-1:0][TAG_BITS-2:0]   req_tag;
  logic [NUM_CLIENTS-1:0][DATA_BITS-1:0]  req_data_bits;
  logic [NUM_CLIENTS-1:0][MASK_BITS-1:0]  req_data_mask;
  logic [NUM_CLIENTS-1:0]                 resp_valid;
  logic [NUM_CLIENTS-1:0][TAG_BITS-2:0]   resp_tag;
  logic [NUM_CLIENTS-1:0][DATA_BITS-1:0]  resp_data;

  assign req_valid      = {c1_req_valid, c0_req_valid};
  assign req_rw         = {c1_req_rw, c0_req_rw};
  assign req_addr       = {c1_req_addr, c0_req_addr};
  assign req_tag        = {c1_req_tag, c0_req_tag};
  assign req_data_valid = {c1_req_data_valid, c0_req_data_valid};
  assign req_data_bits  = {c1_req_data_bits, c0_req_data_bits};
  assign req_data_mask  = {c1_req_data_mask, c0_req_data_mask};

  assign c0_req_ready      = req_ready[0];
  assign c1_req_ready      = req_ready[1];
  assign c0_req_data_ready = req_data_ready[0];
  assign c1_req_data_ready = req_data_ready[1];

  // Request fields follow the registered grant; valids qualify them.
  assign mem_req_rw        = req_rw[grant];
  assign mem_req_addr      = req_addr[grant];
  assign mem_req_tag       = {grant, req_tag[grant]};
  assign mem_req_data_bits = req_data_bits[grant];
  assign mem_req_data_mask = req_data_mask[grant];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    grant_nxt          = grant;
    last_grant_nxt     = last_grant;
    beat_cnt_nxt       = beat_cnt;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    req_ready          = '0;
    req_data_ready     = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          if (&req_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant_nxt = 1'b1;
`else
            grant_nxt = ~last_grant;
`endif
          end else begin
            grant_nxt = req_valid[1];
          end
          last_grant_nxt = grant_nxt;
          state_nxt      = REQ;
        end
      end
      REQ: begin
        mem_req_valid    = 1'b1;
        req_ready[grant] = mem_req_ready;
        if (mem_req_ready) begin
          state_nxt    = req_rw[grant] ? WDATA : IDLE;
          beat_cnt_nxt = '0;
        end
      end
      WDATA: begin
        mem_req_data_valid    = req_data_valid[grant];
        req_data_ready[grant] = mem_req_data_ready;
        if (req_data_valid[grant] && mem_req_data_ready) begin
          if (beat_cnt == CNT_W'(WR_BEATS-1)) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Handshakes stay quiet for the whole reset window, even before the first edge.
    if (!reset) begin
      mem_req_valid      = 1'b0;
      mem_req_data_valid = 1'b0;
      req_ready          = '0;
      req_data_ready     = '0;
    end
  end

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_resp
    mem_arb_resp_lane #(
      .TAG_BITS (TAG_BITS),
      .DATA_BITS(DATA_BITS),
      .CLIENT   (i)
    ) u_lane (
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_tag  (mem_resp_tag),
      .mem_resp_data (mem_resp_data),
      .resp_valid    (resp_valid[i]),
      .resp_tag      (resp_tag[i]),
      .resp_data     (resp_data[i])
    );
  end

  assign c0_resp_valid = resp_valid[0];
  assign c1_resp_valid = resp_valid[1];
  assign c0_resp_tag   = resp_tag[0];
  assign c1_resp_tag   = resp_tag[1];
  assign c0_resp_data  = resp_data[0];
  assign c1_resp_data  = resp_data[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected requests, write beats and responses are
// queued at issue time and checked by a negedge monitor.
module tb_mem_port_arbiter;
  localparam int AB = 28, DB = 128, TB = 5, WB = 4, MB = DB/8;

  logic clk = 1'b0, reset;
  logic c0_req_valid, c0_req_ready, c0_req_rw, c0_req_data_valid, c0_req_data_ready;
  logic [AB-1:0] c0_req_addr; logic [TB-2:0] c0_req_tag;
  logic [DB-1:0] c0_req_data_bits; logic [MB-1:0] c0_req_data_mask;
  logic c0_resp_valid; logic [TB-2:0] c0_resp_tag; logic [DB-1:0] c0_resp_data;
  logic c1_req_valid, c1_req_ready, c1_req_rw, c1_req_data_valid, c1_req_data_ready;
  logic [AB-1:0] c1_req_addr; logic [TB-2:0] c1_req_tag;
  logic [DB-1:0] c1_req_data_bits; logic [MB-1:0] c1_req_data_mask;
  logic c1_resp_valid; logic [TB-2:0] c1_resp_tag; logic [DB-1:0] c1_resp_data;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [AB-1:0] mem_req_addr; logic [TB-1:0] mem_req_tag;
  logic [DB-1:0] mem_req_data_bits; logic [MB-1:0] mem_req_data_mask;
  logic mem_resp_valid; logic [TB-1:0] mem_resp_tag; logic [DB-1:0] mem_resp_data;

  mem_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .TAG_BITS(TB), .WR_BEATS(WB)) dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_rw(c0_req_rw),
    .c0_req_addr(c0_req_addr), .c0_req_tag(c0_req_tag),
    .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
    .c0_req_data_bits(c0_req_data_bits), .c0_req_data_mask(c0_req_data_mask),
    .c0_resp_valid(c0_resp_valid), .c0_resp_tag(c0_resp_tag), .c0_resp_data(c0_resp_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_rw(c1_req_rw),
    .c1_req_addr(c1_req_addr), .c1_req_tag(c1_req_tag),
    .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
    .c1_req_data_bits(c1_req_data_bits), .c1_req_data_mask(c1_req_data_mask),
    .c1_resp_valid(c1_resp_valid), .c1_resp_tag(c1_resp_tag), .c1_resp_data(c1_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [33:0]  rq[$];             // {rw, addr, tag}
  logic [143:0] wq[$];             // {bits, mask}
  logic [265:0] sq[$];             // {c1_v, c0_v, c0_tag, c1_tag, c0_data, c1_data}
  string        dq_nm[$];
  logic [63:0]  dq_act[$], dq_exp[$];
  logic [33:0]  e_r;
  logic [143:0] e_w;
  logic [265:0] e_s;
  string        m_nm;
  logic [63:0]  m_act, m_exp;

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      n_tests++;
      if (rq.size() == 0) begin
        n_fail++; $display("FAIL req_fire: got %h expected none", {mem_req_rw, mem_req_addr, mem_req_tag});
      end else begin
        e_r = rq.pop_front();
        if ({mem_req_rw, mem_req_addr, mem_req_tag} !== e_r) begin
          n_fail++; $display("FAIL req_fire: got %h expected %h", {mem_req_rw, mem_req_addr, mem_req_tag}, e_r);
        end
      end
    end
    if (mem_req_data_valid && mem_req_data_ready) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++; $display("FAIL data_beat: got %h expected none", {mem_req_data_bits, mem_req_data_mask});
      end else begin
        e_w = wq.pop_front();
        if ({mem_req_data_bits, mem_req_data_mask} !== e_w) begin
          n_fail++; $display("FAIL data_beat: got %h expected %h", {mem_req_data_bits, mem_req_data_mask}, e_w);
        end
      end
    end
    if (c0_resp_valid || c1_resp_valid) begin
      n_tests++;
      if (sq.size() == 0) begin
        n_fail++; $display("FAIL resp: got c0v=%b c1v=%b expected none", c0_resp_valid, c1_resp_valid);
      end else begin
        e_s = sq.pop_front();
        if ({c1_resp_valid, c0_resp_valid, c0_resp_tag, c1_resp_tag, c0_resp_data, c1_resp_data} !== e_s) begin
          n_fail++;
          $display("FAIL resp: got %h expected %h",
                   {c1_resp_valid, c0_resp_valid, c0_resp_tag, c1_resp_tag, c0_resp_data, c1_resp_data}, e_s);
        end
      end
    end
    while (dq_nm.size() > 0) begin
      m_nm = dq_nm.pop_front(); m_act = dq_act.pop_front(); m_exp = dq_exp.pop_front();
      n_tests++;
      if (m_act !== m_exp) begin
        n_fail++; $display("FAIL %s: got %h expected %h", m_nm, m_act, m_exp);
      end
    end
  end

  task automatic dchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    dq_nm.push_back(nm); dq_act.push_back(act); dq_exp.push_back(exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic c, input logic v, input logic rw, input logic [AB-1:0] a,
                         input logic [TB-2:0] t);
    if (!c) begin c0_req_valid = v; c0_req_rw = rw; c0_req_addr = a; c0_req_tag = t; end
    else    begin c1_req_valid = v; c1_req_rw = rw; c1_req_addr = a; c1_req_tag = t; end
  endtask

  task automatic push_req(input logic c, input logic rw, input logic [AB-1:0] a, input logic [TB-2:0] t);
    rq.push_back({rw, a, c, t});
  endtask

  task automatic send_resp(input logic [TB-1:0] t, input logic [DB-1:0] d);
    mem_resp_valid = 1'b1; mem_resp_tag = t; mem_resp_data = d;
    sq.push_back({t[TB-1], ~t[TB-1], t[TB-2:0], t[TB-2:0], d, d});
    cyc();
    mem_resp_valid = 1'b0;
  endtask

  task automatic wait_req_ready(input logic c);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((!c) ? c0_req_ready : c1_req_ready) got = 1;
    end
    if (!got) dchk("req_ready_timeout", 64'd0, 64'd1);
    cyc();
  endtask

  task automatic wait_mem_fire();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) got = 1;
    end
    if (!got) dchk("mem_fire_timeout", 64'd0, 64'd1);
    cyc();
  endtask

  // Lone read from IDLE with mem_req_ready=1: request visible one cycle after valid.
  task automatic do_read(input logic c, input logic [AB-1:0] a, input logic [TB-2:0] t);
    set_req(c, 1'b1, 1'b0, a, t); push_req(c, 1'b0, a, t);
    @(negedge clk); dchk("lat_idle", 64'(mem_req_valid), 64'd0);
    @(negedge clk); dchk("lat_req",  64'(mem_req_valid), 64'd1);
    cyc();
    set_req(c, 1'b0, 1'b0, '0, '0);
  endtask

  localparam logic [5:0] QUIET = 6'b0;
  function automatic logic [63:0] hs();
    return 64'({mem_req_valid, mem_req_data_valid, c0_req_ready, c1_req_ready,
                c0_req_data_ready, c1_req_data_ready});
  endfunction

  initial begin
    bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int beat, k, cycles;
    bit req_done, in_w, req_f, dat_f, resp_sent;

    reset = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 28'h1, 4'h1); set_req(1'b1, 1'b0, 1'b0, '0, '0);
    c0_req_data_valid = 0; c0_req_data_bits = '0; c0_req_data_mask = '0;
    c1_req_data_valid = 0; c1_req_data_bits = '0; c1_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
    repeat (3) cyc();
    dchk("reset_quiet", hs(), 64'(QUIET));
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    cyc();
    dchk("idle_quiet", hs(), 64'(QUIET));

    // Continuous tie: round-robin 0,1,0,1 (fixed priority: dcache every time).
    set_req(1'b0, 1'b1, 1'b0, 28'h100, 4'h1);
    set_req(1'b1, 1'b1, 1'b0, 28'h200, 4'h2);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push_req(1'b1, 1'b0, 28'h200, 4'h2);
`else
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_req(1'b0, 1'b0, 28'h100, 4'h1);
      else            push_req(1'b1, 1'b0, 28'h200, 4'h2);
    end
`endif
    for (int i = 0; i < 4; i++) wait_mem_fire();
    set_req(1'b0, 1'b0, 1'b0, '0, '0); set_req(1'b1, 1'b0, 1'b0, '0, '0);
    cyc();

    // icache read and its response; then a dcache response.
    do_read(1'b0, 28'h0000010, 4'h3);
    cyc();
    send_resp(5'h03, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    send_resp(5'h1A, 128'h11112222_33334444_55556666_77778888);

    // dcache write with ready pattern 1,0,1,1,1; icache read held off; response mid-write.
    set_req(1'b1, 1'b1, 1'b1, 28'h20, 4'h2); push_req(1'b1, 1'b1, 28'h20, 4'h2);
    for (int b = 1; b <= 4; b++) wq.push_back({128'(b), 16'hFFFF});
    c1_req_data_valid = 1'b1; c1_req_data_bits = 128'd1; c1_req_data_mask = 16'hFFFF;
    mem_req_data_ready = pat[0];
    beat = 0; k = 0; cycles = 0; req_done = 0; resp_sent = 0;
    while (beat < 4 && cycles < 40) begin
      @(negedge clk);
      req_f = c1_req_ready;
      dat_f = c1_req_data_valid && c1_req_data_ready;
      in_w  = req_done;
      if (in_w) dchk("c0_held", 64'(c0_req_ready), 64'd0);
      cyc(); cycles++;
      mem_resp_valid = 1'b0;
      if (req_f) begin
        req_done = 1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        set_req(1'b0, 1'b1, 1'b0, 28'h30, 4'h1); push_req(1'b0, 1'b0, 28'h30, 4'h1);
      end
      if (in_w) begin
        k++;
        if (k < 5) mem_req_data_ready = pat[k];
      end
      if (dat_f) begin
        beat++;
        c1_req_data_bits = 128'(beat + 1);
        if (beat == 4) c1_req_data_valid = 1'b0;
      end
      if (in_w && k == 1 && !resp_sent) begin
        resp_sent = 1;
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h15; mem_resp_data = 128'h5A5A;
        sq.push_back({1'b1, 1'b0, 4'h5, 4'h5, 128'h5A5A, 128'h5A5A});
      end
    end
    dchk("write_beats", 64'(beat), 64'd4);
    mem_req_data_ready = 1'b0;
    wait_req_ready(1'b0);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    cyc();

    // Stalled request: fields stable and client ready low for 10 cycles.
    mem_req_ready = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 28'h55, 4'h7); push_req(1'b1, 1'b0, 28'h55, 4'h7);
    cyc();
    for (int i = 0; i < 10; i++) begin
      dchk("stall", 64'({mem_req_valid, mem_req_addr, mem_req_tag, c1_req_ready, c0_req_ready}),
           64'({1'b1, 28'h55, 5'h17, 1'b0, 1'b0}));
      cyc();
    end
    mem_req_ready = 1'b1;
    wait_req_ready(1'b1);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    cyc();

    // Reset after 2 of 4 beats: write abandoned, then a normal read.
    set_req(1'b0, 1'b1, 1'b1, 28'h40, 4'h4); push_req(1'b0, 1'b1, 28'h40, 4'h4);
    wq.push_back({128'hA1, 16'h00FF}); wq.push_back({128'hA2, 16'h00FF});
    c0_req_data_valid = 1'b1; c0_req_data_bits = 128'hA1; c0_req_data_mask = 16'h00FF;
    mem_req_data_ready = 1'b1;
    beat = 0; cycles = 0;
    while (beat < 2 && cycles < 40) begin
      @(negedge clk);
      req_f = c0_req_ready;
      dat_f = c0_req_data_valid && c0_req_data_ready;
      cyc(); cycles++;
      if (req_f) set_req(1'b0, 1'b0, 1'b0, '0, '0);
      if (dat_f) begin beat++; c0_req_data_bits = 128'hA1 + 128'(beat); end
    end
    dchk("rst_beats", 64'(beat), 64'd2);
    reset = 1'b0;
    @(negedge clk); dchk("rst_in_wdata", hs(), 64'(QUIET));
    cyc();
    dchk("rst_held", hs(), 64'(QUIET));
    c0_req_data_valid = 1'b0; mem_req_data_ready = 1'b0;
    reset = 1'b1;
    cyc();
    dchk("post_rst_idle", hs(), 64'(QUIET));
    do_read(1'b0, 28'h77, 4'h9);

    repeat (3) cyc();
    dchk("sb_drained", 64'(rq.size() + wq.size() + sq.size()), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
